// File: rtl/simple_tx_arbiter.sv
// -----------------------------------------------------------------------------
// simple_tx_arbiter
//
// Shares one simple_transmitter between NUM_CHANNELS FIFO-style requesters.
// Round-robin grant with a burst-limited hold. Presents a single
// first-word-fall-through FIFO read interface (din/empty/re) to the transmitter.
//
// Optional feature (compile-time macro TX_ARB_HEADER_EN):
//   defined   - every grant first sends one header word HEADER_BASE + grant.
//               The header does not count toward MAX_BURST.
//   undefined - no HEADER state; IDLE goes straight to DATA and HEADER_BASE
//               is unused.
//
// Ports
//   clk        in   1                        system clock
//   rst        in   1                        synchronous, active-high reset
//   req_din    in   NUM_CHANNELS*WORD_WIDTH  channel i word at [i*WORD_WIDTH +: WORD_WIDTH]
//   req_empty  in   NUM_CHANNELS             1 = channel FIFO empty
//   req_re     out  NUM_CHANNELS             pop strobe per channel
//   tx_din     out  WORD_WIDTH               to transmitter din
//   tx_empty   out  1                        to transmitter empty
//   tx_re      in   1                        from transmitter re
//   grant      out  $clog2(NUM_CHANNELS)     currently granted channel
//   busy       out  1                        1 while a grant is being served
// -----------------------------------------------------------------------------
module simple_tx_arbiter #(
  parameter int                    NUM_CHANNELS = 4,
  parameter int                    WORD_WIDTH   = 8,
  parameter int                    MAX_BURST    = 16,
  parameter logic [WORD_WIDTH-1:0] HEADER_BASE  = WORD_WIDTH'(8'h80)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] req_din,
  input  logic [NUM_CHANNELS-1:0]            req_empty,
  output logic [NUM_CHANNELS-1:0]            req_re,
  output logic [WORD_WIDTH-1:0]              tx_din,
  output logic                               tx_empty,
  input  logic                               tx_re,
  output logic [$clog2(NUM_CHANNELS)-1:0]    grant,
  output logic                               busy
);

  localparam int GW = $clog2(NUM_CHANNELS);
  localparam int SW = GW + 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [GW-1:0] LAST_CH    = GW'(NUM_CHANNELS - 1);
  localparam logic [SW-1:0] NCH_WIDE   = SW'(NUM_CHANNELS);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef TX_ARB_HEADER_EN
    ST_HEADER = 2'd2,
`endif
    ST_DATA   = 2'd1
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [GW-1:0]   rr_ptr, rr_nxt;
  logic [CW-1:0]   burst_cnt, cnt_nxt;

  logic [WORD_WIDTH-1:0] ch_din [NUM_CHANNELS];
  logic                  found;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         next_ch;
  logic                  pop;

`ifndef TX_ARB_HEADER_EN
  // Header word is only emitted when the header feature is compiled in.
  logic unused_header_base;
  assign unused_header_base = ^HEADER_BASE;
`endif

  // Unpack the flat data bus into one word per channel.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_split
    assign ch_din[i] = req_din[i*WORD_WIDTH +: WORD_WIDTH];
  end

  // Channel after the granted one, wrapping at NUM_CHANNELS; becomes rr_ptr on
  // burst exit so the channel just served moves to the back of the queue.
  assign next_ch = (grant == LAST_CH) ? '0 : grant + 1'b1;

  // Round-robin search: first non-empty channel starting at rr_ptr.
  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    logic [SW-1:0] sum;
    logic [GW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= NCH_WIDE) sum = sum - NCH_WIDE;
      idx = sum[GW-1:0];
      if (!found && !req_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = burst_cnt;
    tx_empty  = 1'b1;
    tx_din    = '0;
    req_re    = '0;
    pop       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_nxt = pick;
          cnt_nxt   = '0;
`ifdef TX_ARB_HEADER_EN
          state_nxt = ST_HEADER;
`else
          state_nxt = ST_DATA;
`endif
        end
      end

`ifdef TX_ARB_HEADER_EN
      ST_HEADER: begin
        tx_empty = 1'b0;
        tx_din   = HEADER_BASE + WORD_WIDTH'(grant);
        if (tx_re) state_nxt = ST_DATA;
      end
`endif

      ST_DATA: begin
        tx_din        = ch_din[grant];
        tx_empty      = req_empty[grant];
        // tx_re against an empty channel is ignored: no pop, no count.
        pop           = tx_re & ~req_empty[grant];
        req_re[grant] = pop;
        if (pop) begin
          cnt_nxt = burst_cnt + 1'b1;
          if (burst_cnt == BURST_LAST) begin
            state_nxt = ST_IDLE;
            rr_nxt    = next_ch;
          end
        end else if (req_empty[grant]) begin
          // Channel drained before the burst limit: release early.
          state_nxt = ST_IDLE;
          rr_nxt    = next_ch;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and covers all state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_simple_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_simple_tx_arbiter
//
// Self-checking bench for simple_tx_arbiter. Per-channel source FIFOs and a
// transmitter stand-in are modelled here; directed tests push the hand-ordered
// expected word stream into a scoreboard queue, and a monitor pops and compares
// each word the transmitter accepts. Builds with or without TX_ARB_HEADER_EN.
// -----------------------------------------------------------------------------
module tb_simple_tx_arbiter;

  localparam int NCH = 4;
  localparam int WW  = 8;
  localparam int MB  = 16;
  localparam logic [7:0] HB = 8'h80;
`ifdef TX_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BIG = 1000000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*WW-1:0] req_din = '0;
  logic [NCH-1:0]    req_empty = '1;
  logic [NCH-1:0]    req_re;
  logic [WW-1:0]     tx_din;
  logic              tx_empty;
  logic              tx_re = 1'b0;
  logic [1:0]        grant;
  logic              busy;

  simple_tx_arbiter #(
    .NUM_CHANNELS (NCH),
    .WORD_WIDTH   (WW),
    .MAX_BURST    (MB),
    .HEADER_BASE  (HB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_din   (req_din),
    .req_empty (req_empty),
    .req_re    (req_re),
    .tx_din    (tx_din),
    .tx_empty  (tx_empty),
    .tx_re     (tx_re),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source FIFO models.
  logic [7:0] src_mem [NCH][256];
  int         src_head [NCH];
  int         src_tail [NCH];
  int         pulses [NCH];
  logic [NCH-1:0] pend = '0;

  // Scoreboard.
  typedef struct packed {
    logic       hdr;
    logic [1:0] ch;
    logic [7:0] word;
  } exp_t;
  exp_t exp_q[$];

  // Transmitter stand-in: accepts words while tx_budget > 0; in slow mode it
  // asserts tx_re only every other cycle.
  int tx_budget = 0;
  bit slow  = 1'b0;
  bit phase = 1'b0;

  task automatic push_src(input int ch, input logic [7:0] w);
    src_mem[ch][src_tail[ch] % 256] = w;
    src_tail[ch]++;
  endtask

  task automatic expect_word(input int ch, input logic [7:0] w);
    exp_t e;
    e.hdr  = 1'b0;
    e.ch   = 2'(ch);
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic expect_grant(input int ch);
    exp_t e;
    if (HDR != 0) begin
      e.hdr  = 1'b1;
      e.ch   = 2'(ch);
      e.word = HB + 8'(ch);
      exp_q.push_back(e);
    end
  endtask

  // Environment + monitor: inputs change on the falling edge, outputs are
  // sampled 1 ns later, well away from the rising edge.
  initial begin : env
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      pulses[i]   = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) if (pend[i]) src_head[i]++;
      for (int i = 0; i < NCH; i++) begin
        req_empty[i] = (src_head[i] == src_tail[i]);
        req_din[i*WW +: WW] = req_empty[i] ? 8'h00 : src_mem[i][src_head[i] % 256];
      end
      phase = ~phase;
      tx_re = (tx_budget > 0) && (!slow || phase);
      #1;
      pend = req_re;
      for (int i = 0; i < NCH; i++) if (req_re[i]) pulses[i]++;
      if (tx_re && !tx_empty) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got %0h with empty scoreboard (t=%0t)", tx_din, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_din", 32'(tx_din), 32'(e.word));
          check("grant", 32'(grant), 32'(e.ch));
          check("req_re_xfer", 32'(req_re), e.hdr ? 32'd0 : (32'd1 << e.ch));
        end
        tx_budget--;
      end else begin
        check("req_re_quiet", 32'(req_re), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int n;

    // Reset state.
    tick(3);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_req_re", 32'(req_re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);

    // All channels loaded from reset: grants 0,1,2,3 with full bursts, then
    // 0,1,2,3 again with the 4-word remainders.
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 20; i++) push_src(c, 8'(c * 64 + i));
    for (int c = 0; c < NCH; c++) begin
      expect_grant(c);
      for (int i = 0; i < MB; i++) expect_word(c, 8'(c * 64 + i));
    end
    for (int c = 0; c < NCH; c++) begin
      expect_grant(c);
      for (int i = MB; i < 20; i++) expect_word(c, 8'(c * 64 + i));
    end
    tx_budget = BIG;
    rst = 1'b0;
    wait_drain("round_robin", 600);

    // Ch2 alone, transmitter pulsing tx_re every other cycle.
    slow = 1'b1;
    base = pulses[2];
    push_src(2, 8'h11);
    push_src(2, 8'h22);
    push_src(2, 8'h33);
    expect_grant(2);
    expect_word(2, 8'h11);
    expect_word(2, 8'h22);
    expect_word(2, 8'h33);
    tick(1);
    check("arb_before_edge_busy", 32'(busy), 32'd0);
    tick(1);
    check("arb_one_cycle_busy", 32'(busy), 32'd1);
    check("arb_one_cycle_grant", 32'(grant), 32'd2);
    check("arb_one_cycle_tx_empty", 32'(tx_empty), 32'd0);
    n = 0;
    while (pulses[2] != base + 3 && n < 100) begin
      tick(1);
      n++;
    end
    check("ch2_pulses_seen", 32'(pulses[2] - base), 32'd3);
    tick(1);
    check("ch2_empty_still_busy", 32'(busy), 32'd1);
    check("ch2_empty_tx_empty", 32'(tx_empty), 32'd1);
    tick(1);
    check("ch2_release_idle", 32'(busy), 32'd0);
    check("ch2_grant_held", 32'(grant), 32'd2);
    tick(3);
    check("ch2_pulse_count", 32'(pulses[2] - base), 32'd3);
    wait_drain("ch2_only", 100);
    slow = 1'b0;

    // rr_ptr now 3: with ch1 and ch3 both pending, ch3 goes first.
    push_src(1, 8'h5A);
    push_src(3, 8'hC3);
    expect_grant(3);
    expect_word(3, 8'hC3);
    expect_grant(1);
    expect_word(1, 8'h5A);
    wait_drain("rr_after_ch2", 100);

    // Reset mid-burst on ch1 after 5 accepted words.
    tx_budget = 0;
    tick(1);
    for (int i = 0; i < MB; i++) push_src(1, 8'(8'h40 + i));
    expect_grant(1);
    for (int i = 0; i < 5 - HDR; i++) expect_word(1, 8'(8'h40 + i));
    tx_budget = 5;
    n = 0;
    while (tx_budget != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check("midburst_budget_used", 32'(tx_budget), 32'd0);
    push_src(0, 8'h01);
    push_src(0, 8'h02);
    tick(2);
    check("no_preempt_busy", 32'(busy), 32'd1);
    check("no_preempt_grant", 32'(grant), 32'd1);
    rst = 1'b1;
    tick(1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_re", 32'(req_re), 32'd0);
    check("midrst_tx_empty", 32'(tx_empty), 32'd1);
    check("midrst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    expect_grant(0);
    expect_word(0, 8'h01);
    expect_word(0, 8'h02);
    expect_grant(1);
    for (int i = 5 - HDR; i < MB; i++) expect_word(1, 8'(8'h40 + i));
    tx_budget = BIG;
    wait_drain("after_midrst", 200);

    // Single word on ch3 (header 0x83 precedes it when headers are enabled).
    base = pulses[3];
    push_src(3, 8'hA5);
    expect_grant(3);
    expect_word(3, 8'hA5);
    wait_drain("ch3_single", 100);
    tick(2);
    check("ch3_pulse_count", 32'(pulses[3] - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
